// File: rtl/host_wg_issue_queue_pkg.sv
// ----------------------------------------------------------------------------
// host_wg_pkg : shared descriptor layout (packed MSB-first) and FSM encoding
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package host_wg_pkg;

  localparam int WG_ID_WIDTH     = 6;
  localparam int WF_COUNT_WIDTH  = 4;
  localparam int WAVE_ITEM_WIDTH = 6;
  localparam int VGPR_ID_WIDTH   = 8;
  localparam int SGPR_ID_WIDTH   = 4;
  localparam int LDS_ID_WIDTH    = 8;
  localparam int GDS_ID_WIDTH    = 14;
  localparam int MEM_ADDR_WIDTH  = 32;

  localparam int VGPR_SZ_WIDTH = VGPR_ID_WIDTH + 1;
  localparam int SGPR_SZ_WIDTH = SGPR_ID_WIDTH + 1;
  localparam int LDS_SZ_WIDTH  = LDS_ID_WIDTH + 1;
  localparam int GDS_SZ_WIDTH  = GDS_ID_WIDTH + 1;

  // LSB offsets, start_pc occupies the bottom of the word
  localparam int OFF_START_PC    = 0;
  localparam int OFF_GDS_TOTAL   = OFF_START_PC + MEM_ADDR_WIDTH;
  localparam int OFF_LDS_TOTAL   = OFF_GDS_TOTAL + GDS_SZ_WIDTH;
  localparam int OFF_SGPR_PER_WF = OFF_LDS_TOTAL + LDS_SZ_WIDTH;
  localparam int OFF_SGPR_TOTAL  = OFF_SGPR_PER_WF + SGPR_SZ_WIDTH;
  localparam int OFF_VGPR_PER_WF = OFF_SGPR_TOTAL + SGPR_SZ_WIDTH;
  localparam int OFF_VGPR_TOTAL  = OFF_VGPR_PER_WF + VGPR_SZ_WIDTH;
  localparam int OFF_WF_SIZE     = OFF_VGPR_TOTAL + VGPR_SZ_WIDTH;
  localparam int OFF_NUM_WF      = OFF_WF_SIZE + WAVE_ITEM_WIDTH;
  localparam int OFF_WG_ID       = OFF_NUM_WF + WF_COUNT_WIDTH;
  localparam int DESC_WIDTH      = OFF_WG_ID + WG_ID_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/host_wg_issue_queue_if.sv
// ----------------------------------------------------------------------------
// host_wg_issue_queue_if : loader push port and dispatcher issue port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface host_wg_issue_queue_if;
  import host_wg_pkg::*;

  logic                      load_valid;
  logic                      load_ready;
  logic [DESC_WIDTH-1:0]     load_desc;
  logic                      load_err;
  logic                      inflight_wg_buffer_host_rcvd_ack;
  logic                      host_wg_valid;
  logic [WG_ID_WIDTH-1:0]    host_wg_id;
  logic [WF_COUNT_WIDTH-1:0] host_num_wf;
  logic [WAVE_ITEM_WIDTH-1:0] host_wf_size;
  logic [VGPR_SZ_WIDTH-1:0]  host_vgpr_size_per_wf;
  logic [VGPR_SZ_WIDTH-1:0]  host_vgpr_size_total;
  logic [SGPR_SZ_WIDTH-1:0]  host_sgpr_size_per_wf;
  logic [SGPR_SZ_WIDTH-1:0]  host_sgpr_size_total;
  logic [LDS_SZ_WIDTH-1:0]   host_lds_size_total;
  logic [GDS_SZ_WIDTH-1:0]   host_gds_size_total;
  logic [MEM_ADDR_WIDTH-1:0] host_start_pc;

  modport master (
    output load_valid, load_desc, inflight_wg_buffer_host_rcvd_ack,
    input  load_ready, load_err, host_wg_valid, host_wg_id, host_num_wf,
           host_wf_size, host_vgpr_size_per_wf, host_vgpr_size_total,
           host_sgpr_size_per_wf, host_sgpr_size_total, host_lds_size_total,
           host_gds_size_total, host_start_pc
  );

  modport slave (
    input  load_valid, load_desc, inflight_wg_buffer_host_rcvd_ack,
    output load_ready, load_err, host_wg_valid, host_wg_id, host_num_wf,
           host_wf_size, host_vgpr_size_per_wf, host_vgpr_size_total,
           host_sgpr_size_per_wf, host_sgpr_size_total, host_lds_size_total,
           host_gds_size_total, host_start_pc
  );

endinterface

`default_nettype wire

// File: rtl/host_wg_issue_queue_fifo.sv
// ----------------------------------------------------------------------------
// host_wg_desc_fifo : power-of-2 descriptor FIFO, head visible combinationally
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module host_wg_desc_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 100
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push_i,
  input  wire logic             pop_i,
  input  wire logic [WIDTH-1:0] wdata_i,
  output logic      [WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             w_push, w_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (w_push && !w_pop)      count_d = count_q + CNT_ONE;
    else if (w_pop && !w_push) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/host_wg_issue_queue.sv
// ----------------------------------------------------------------------------
// host_wg_issue_queue : queued WG descriptor issue with gap and total count.
// Optional malformed-descriptor check: HOST_DESC_CHECK_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module host_wg_issue_queue
  import host_wg_pkg::*;
#(
  parameter int QUEUE_DEPTH = 8,
  parameter int GAP_WIDTH   = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   start,
  input  wire logic [WG_ID_WIDTH:0]   cfg_total_wg,
  input  wire logic [GAP_WIDTH-1:0]   cfg_gap,
  host_wg_issue_queue_if.slave        bus,
  output logic      [WG_ID_WIDTH:0]   issued_count,
  output logic                        all_wf_dispatched
);

  localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);
  localparam logic [WG_ID_WIDTH:0] CNT_ONE = (WG_ID_WIDTH+1)'(1);

  logic [1:0]            state_q, state_d;
  logic [WG_ID_WIDTH:0]  total_q, total_d;
  logic [WG_ID_WIDTH:0]  issued_q, issued_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DESC_WIDTH-1:0] w_head, w_head_vis;
  logic [WG_ID_WIDTH:0]  w_issued_inc;
  logic                  w_full, w_empty, w_load_hs, w_push, w_pop, w_desc_ok;

  host_wg_desc_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (DESC_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (bus.load_desc),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign bus.load_ready    = !w_full;
  assign w_load_hs         = bus.load_valid && !w_full;
  assign w_push            = w_load_hs && w_desc_ok;
  assign bus.host_wg_valid = (state_q == ST_RUN) && !w_empty;
  assign w_pop             = bus.host_wg_valid && bus.inflight_wg_buffer_host_rcvd_ack;
  assign w_issued_inc      = issued_q + CNT_ONE;
  assign issued_count      = issued_q;
  assign all_wf_dispatched = (state_q == ST_DONE);

  // Stale storage must not leak onto the bus when nothing is queued
  assign w_head_vis = w_empty ? '0 : w_head;

  assign bus.host_wg_id            = w_head_vis[OFF_WG_ID       +: WG_ID_WIDTH];
  assign bus.host_num_wf           = w_head_vis[OFF_NUM_WF      +: WF_COUNT_WIDTH];
  assign bus.host_wf_size          = w_head_vis[OFF_WF_SIZE     +: WAVE_ITEM_WIDTH];
  assign bus.host_vgpr_size_total  = w_head_vis[OFF_VGPR_TOTAL  +: VGPR_SZ_WIDTH];
  assign bus.host_vgpr_size_per_wf = w_head_vis[OFF_VGPR_PER_WF +: VGPR_SZ_WIDTH];
  assign bus.host_sgpr_size_total  = w_head_vis[OFF_SGPR_TOTAL  +: SGPR_SZ_WIDTH];
  assign bus.host_sgpr_size_per_wf = w_head_vis[OFF_SGPR_PER_WF +: SGPR_SZ_WIDTH];
  assign bus.host_lds_size_total   = w_head_vis[OFF_LDS_TOTAL   +: LDS_SZ_WIDTH];
  assign bus.host_gds_size_total   = w_head_vis[OFF_GDS_TOTAL   +: GDS_SZ_WIDTH];
  assign bus.host_start_pc         = w_head_vis[OFF_START_PC    +: MEM_ADDR_WIDTH];

`ifdef HOST_DESC_CHECK_EN
  localparam int VPROD_W = VGPR_SZ_WIDTH + WF_COUNT_WIDTH;
  localparam int SPROD_W = SGPR_SZ_WIDTH + WF_COUNT_WIDTH;

  logic [WF_COUNT_WIDTH-1:0] w_chk_nwf;
  logic [VPROD_W-1:0]        w_vgpr_prod, w_vgpr_tot;
  logic [SPROD_W-1:0]        w_sgpr_prod, w_sgpr_tot;
  logic                      load_err_q;

  assign w_chk_nwf   = bus.load_desc[OFF_NUM_WF +: WF_COUNT_WIDTH];
  assign w_vgpr_prod = {{WF_COUNT_WIDTH{1'b0}}, bus.load_desc[OFF_VGPR_PER_WF +: VGPR_SZ_WIDTH]}
                     * {{VGPR_SZ_WIDTH{1'b0}}, w_chk_nwf};
  assign w_sgpr_prod = {{WF_COUNT_WIDTH{1'b0}}, bus.load_desc[OFF_SGPR_PER_WF +: SGPR_SZ_WIDTH]}
                     * {{SGPR_SZ_WIDTH{1'b0}}, w_chk_nwf};
  assign w_vgpr_tot  = {{WF_COUNT_WIDTH{1'b0}}, bus.load_desc[OFF_VGPR_TOTAL +: VGPR_SZ_WIDTH]};
  assign w_sgpr_tot  = {{WF_COUNT_WIDTH{1'b0}}, bus.load_desc[OFF_SGPR_TOTAL +: SGPR_SZ_WIDTH]};
  assign w_desc_ok   = (w_chk_nwf != '0) && (w_vgpr_prod == w_vgpr_tot)
                    && (w_sgpr_prod == w_sgpr_tot);
  assign bus.load_err = load_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) load_err_q <= 1'b0;
    else      load_err_q <= w_load_hs && !w_desc_ok;
  end
`else
  assign w_desc_ok    = 1'b1;
  assign bus.load_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    issued_d  = issued_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          total_d  = cfg_total_wg;
          gap_d    = cfg_gap;
          issued_d = '0;
          state_d  = (cfg_total_wg == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_pop) begin
          issued_d = w_issued_inc;
          if (w_issued_inc == total_q) begin
            state_d = ST_DONE;
          end else if (gap_q != '0) begin
            state_d   = ST_GAP;
            gap_cnt_d = gap_q;
          end
        end
      end
      ST_GAP: begin
        // Counter loaded with gap and left at 1 gives exactly gap idle cycles
        if (gap_cnt_q <= GAP_ONE) state_d   = ST_RUN;
        else                      gap_cnt_d = gap_cnt_q - GAP_ONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      total_q   <= '0;
      issued_q  <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      issued_q  <= issued_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_host_wg_issue_queue.sv
// ----------------------------------------------------------------------------
// tb_host_wg_issue_queue : directed self-checking bench for host_wg_issue_queue
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_host_wg_issue_queue;
  import host_wg_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] cfg_total_wg;
  logic [3:0] cfg_gap;
  logic [6:0] issued_count;
  logic       all_wf_dispatched;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  host_wg_issue_queue_if bus();

  host_wg_issue_queue #(
    .QUEUE_DEPTH (8),
    .GAP_WIDTH   (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .cfg_total_wg      (cfg_total_wg),
    .cfg_gap           (cfg_gap),
    .bus               (bus),
    .issued_count      (issued_count),
    .all_wf_dispatched (all_wf_dispatched)
  );

  // Layout MSB-first: id, num_wf, wf_size, vgpr_tot, vgpr_per, sgpr_tot, sgpr_per, lds, gds, pc
  function automatic logic [99:0] mk(input int id, input int nwf, input int vpw, input int vtot);
    logic [99:0] d;
    d = {6'(id), 4'(nwf), 6'(id + 1), 9'(vtot), 9'(vpw), 5'(6), 5'(3),
         9'(id + 7), 15'(id + 100), 32'h4000_0000 + 32'(id * 4)};
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [99:0] d);
    bus.load_valid = 1'b1;
    bus.load_desc  = d;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic do_start(input int total, input int gap);
    start        = 1'b1;
    cfg_total_wg = 7'(total);
    cfg_gap      = 4'(gap);
    tick();
    start        = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; cfg_total_wg = '0; cfg_gap = '0;
    bus.load_valid = 1'b0; bus.load_desc = '0; bus.inflight_wg_buffer_host_rcvd_ack = 1'b0;
    tick();
    n_tests++;
    if ({bus.host_wg_valid, issued_count, all_wf_dispatched, bus.load_err, bus.load_ready}
        !== {1'b0, 7'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b cnt=%0d all=%0b err=%0b rdy=%0b want 0 0 0 0 1",
               bus.host_wg_valid, issued_count, all_wf_dispatched, bus.load_err, bus.load_ready);
    end
    n_tests++;
    if ({bus.host_wg_id, bus.host_start_pc, dut.u_fifo.count_q} !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: got id=%0d pc=%0h occ=%0d want 0 0 0",
               bus.host_wg_id, bus.host_start_pc, dut.u_fifo.count_q);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) push(mk(i, 2, 10, 20));
    bus.inflight_wg_buffer_host_rcvd_ack = 1'b1;
    do_start(3, 0);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({bus.host_wg_valid, bus.host_wg_id, issued_count} !== {1'b1, 6'(i), 7'(i)}) begin
        n_fail++;
        $display("FAIL b2b_issue[%0d]: got v=%0b id=%0d cnt=%0d want 1 %0d %0d",
                 i, bus.host_wg_valid, bus.host_wg_id, issued_count, i, i);
      end
      n_tests++;
      if ({bus.host_start_pc, bus.host_vgpr_size_total, bus.host_wf_size}
          !== {32'h4000_0000 + 32'(i * 4), 9'd20, 6'(i + 1)}) begin
        n_fail++;
        $display("FAIL b2b_fields[%0d]: got pc=%0h vtot=%0d wfs=%0d want pc=%0h vtot=20 wfs=%0d",
                 i, bus.host_start_pc, bus.host_vgpr_size_total, bus.host_wf_size,
                 32'h4000_0000 + 32'(i * 4), i + 1);
      end
      tick();
    end
    n_tests++;
    if ({all_wf_dispatched, bus.host_wg_valid, issued_count} !== {1'b1, 1'b0, 7'd3}) begin
      n_fail++;
      $display("FAIL b2b_done: got all=%0b v=%0b cnt=%0d want 1 0 3",
               all_wf_dispatched, bus.host_wg_valid, issued_count);
    end
    bus.inflight_wg_buffer_host_rcvd_ack = 1'b0;
  endtask

  task automatic test_ack_hold();
    push(mk(5, 2, 10, 20));
    push(mk(6, 2, 10, 20));
    do_start(2, 0);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if ({bus.host_wg_valid, bus.host_wg_id, bus.host_gds_size_total, dut.u_fifo.count_q}
          !== {1'b1, 6'd5, 15'd105, 4'd2}) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got v=%0b id=%0d gds=%0d occ=%0d want 1 5 105 2",
                 k, bus.host_wg_valid, bus.host_wg_id, bus.host_gds_size_total, dut.u_fifo.count_q);
      end
      tick();
    end
    bus.inflight_wg_buffer_host_rcvd_ack = 1'b1;
    tick();
    bus.inflight_wg_buffer_host_rcvd_ack = 1'b0;
    n_tests++;
    if ({bus.host_wg_valid, bus.host_wg_id, issued_count, dut.u_fifo.count_q}
        !== {1'b1, 6'd6, 7'd1, 4'd1}) begin
      n_fail++;
      $display("FAIL hold_single_pop: got v=%0b id=%0d cnt=%0d occ=%0d want 1 6 1 1",
               bus.host_wg_valid, bus.host_wg_id, issued_count, dut.u_fifo.count_q);
    end
    bus.inflight_wg_buffer_host_rcvd_ack = 1'b1;
    tick();
    bus.inflight_wg_buffer_host_rcvd_ack = 1'b0;
    n_tests++;
    if ({all_wf_dispatched, issued_count} !== {1'b1, 7'd2}) begin
      n_fail++;
      $display("FAIL hold_done: got all=%0b cnt=%0d want 1 2", all_wf_dispatched, issued_count);
    end
  endtask

  task automatic test_gap();
    logic [4:0] exp_v;
    exp_v = 5'b01001;
    push(mk(10, 2, 10, 20));
    push(mk(11, 2, 10, 20));
    bus.inflight_wg_buffer_host_rcvd_ack = 1'b1;
    do_start(2, 2);
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (bus.host_wg_valid !== exp_v[c]) begin
        n_fail++;
        $display("FAIL gap_valid[%0d]: got %0b want %0b", c, bus.host_wg_valid, exp_v[c]);
      end
      if (c == 3) begin
        n_tests++;
        if (bus.host_wg_id !== 6'd11) begin
          n_fail++;
          $display("FAIL gap_second_id: got %0d want 11", bus.host_wg_id);
        end
      end
      tick();
    end
    n_tests++;
    if ({all_wf_dispatched, issued_count} !== {1'b1, 7'd2}) begin
      n_fail++;
      $display("FAIL gap_done: got all=%0b cnt=%0d want 1 2", all_wf_dispatched, issued_count);
    end
    bus.inflight_wg_buffer_host_rcvd_ack = 1'b0;
  endtask

  task automatic test_full();
    bus.load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.load_desc = mk(20 + i, 2, 10, 20);
      tick();
    end
    bus.load_desc = mk(28, 2, 10, 20);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({bus.load_ready, dut.u_fifo.count_q} !== {1'b0, 4'd8}) begin
        n_fail++;
        $display("FAIL full_stall[%0d]: got rdy=%0b occ=%0d want 0 8",
                 k, bus.load_ready, dut.u_fifo.count_q);
      end
      tick();
    end
    do_start(2, 0);
    bus.inflight_wg_buffer_host_rcvd_ack = 1'b1;
    tick();
    n_tests++;
    if ({bus.load_ready, dut.u_fifo.count_q, bus.host_wg_id} !== {1'b1, 4'd7, 6'd21}) begin
      n_fail++;
      $display("FAIL full_pop: got rdy=%0b occ=%0d id=%0d want 1 7 21",
               bus.load_ready, dut.u_fifo.count_q, bus.host_wg_id);
    end
    tick();
    bus.load_valid = 1'b0;
    n_tests++;
    if ({dut.u_fifo.count_q, all_wf_dispatched, bus.host_wg_id} !== {4'd7, 1'b1, 6'd22}) begin
      n_fail++;
      $display("FAIL full_push_pop: got occ=%0d all=%0b head=%0d want 7 1 22",
               dut.u_fifo.count_q, all_wf_dispatched, bus.host_wg_id);
    end
    do_start(7, 0);
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if ({bus.host_wg_valid, bus.host_wg_id} !== {1'b1, 6'(22 + i)}) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got v=%0b id=%0d want 1 %0d",
                 i, bus.host_wg_valid, bus.host_wg_id, 22 + i);
      end
      tick();
    end
    n_tests++;
    if ({all_wf_dispatched, dut.u_fifo.count_q, bus.host_wg_id} !== {1'b1, 4'd0, 6'd0}) begin
      n_fail++;
      $display("FAIL drain_empty: got all=%0b occ=%0d id=%0d want 1 0 0",
               all_wf_dispatched, dut.u_fifo.count_q, bus.host_wg_id);
    end
    bus.inflight_wg_buffer_host_rcvd_ack = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 3; i++) push(mk(30 + i, 2, 10, 20));
    do_start(3, 0);
    bus.inflight_wg_buffer_host_rcvd_ack = 1'b1;
    tick();
    bus.inflight_wg_buffer_host_rcvd_ack = 1'b0;
    n_tests++;
    if ({bus.host_wg_valid, bus.host_wg_id, issued_count} !== {1'b1, 6'd31, 7'd1}) begin
      n_fail++;
      $display("FAIL midrun_pre: got v=%0b id=%0d cnt=%0d want 1 31 1",
               bus.host_wg_valid, bus.host_wg_id, issued_count);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.host_wg_valid, issued_count, all_wf_dispatched, bus.host_wg_id,
         dut.u_fifo.count_q, bus.load_ready} !== {1'b0, 7'd0, 1'b0, 6'd0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL midrun_async_reset: got v=%0b cnt=%0d all=%0b id=%0d occ=%0d rdy=%0b want 0 0 0 0 0 1",
               bus.host_wg_valid, issued_count, all_wf_dispatched, bus.host_wg_id,
               dut.u_fifo.count_q, bus.load_ready);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_zero_total();
    n_tests++;
    if (all_wf_dispatched !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_idle: got all=%0b want 0", all_wf_dispatched);
    end
    push(mk(40, 2, 10, 20));
    do_start(0, 0);
    bus.inflight_wg_buffer_host_rcvd_ack = 1'b1;
    n_tests++;
    if ({all_wf_dispatched, bus.host_wg_valid, issued_count} !== {1'b1, 1'b0, 7'd0}) begin
      n_fail++;
      $display("FAIL zero_done: got all=%0b v=%0b cnt=%0d want 1 0 0",
               all_wf_dispatched, bus.host_wg_valid, issued_count);
    end
    tick();
    n_tests++;
    if (dut.u_fifo.count_q !== 4'd1) begin
      n_fail++;
      $display("FAIL zero_ack_ignored: got occ=%0d want 1", dut.u_fifo.count_q);
    end
    do_start(1, 0);
    n_tests++;
    if ({all_wf_dispatched, bus.host_wg_valid, bus.host_wg_id} !== {1'b0, 1'b1, 6'd40}) begin
      n_fail++;
      $display("FAIL rearm_leftover: got all=%0b v=%0b id=%0d want 0 1 40",
               all_wf_dispatched, bus.host_wg_valid, bus.host_wg_id);
    end
    tick();
    bus.inflight_wg_buffer_host_rcvd_ack = 1'b0;
    n_tests++;
    if ({all_wf_dispatched, issued_count, dut.u_fifo.count_q} !== {1'b1, 7'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL rearm_done: got all=%0b cnt=%0d occ=%0d want 1 1 0",
               all_wf_dispatched, issued_count, dut.u_fifo.count_q);
    end
  endtask

  task automatic test_desc_check();
    logic       exp_err;
    logic [3:0] exp_occ;
`ifdef HOST_DESC_CHECK_EN
    exp_err = 1'b1; exp_occ = 4'd0;
`else
    exp_err = 1'b0; exp_occ = 4'd1;
`endif
    push(mk(50, 2, 10, 21));
    n_tests++;
    if ({bus.load_err, dut.u_fifo.count_q} !== {exp_err, exp_occ}) begin
      n_fail++;
      $display("FAIL chk_bad: got err=%0b occ=%0d want %0b %0d",
               bus.load_err, dut.u_fifo.count_q, exp_err, exp_occ);
    end
    tick();
    n_tests++;
    if (bus.load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL chk_pulse_len: got err=%0b want 0", bus.load_err);
    end
    push(mk(51, 2, 10, 20));
    n_tests++;
    if ({bus.load_err, dut.u_fifo.count_q} !== {1'b0, exp_occ + 4'd1}) begin
      n_fail++;
      $display("FAIL chk_good: got err=%0b occ=%0d want 0 %0d",
               bus.load_err, dut.u_fifo.count_q, exp_occ + 4'd1);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ack_hold();
    test_gap();
    test_full();
    test_reset_mid_run();
    test_zero_total();
    test_desc_check();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
